keccak_arbiter: RTL

Two-requester message scheduler in front of a single `keccak` hash core. Grants the core to one requester per message (round-robin) and pulses the core reset before each message. It forwards the granted requester's word stream, including backpressure, and waits for the digest. It then returns the digest to that requester with a one-cycle `done` pulse. It sits between the message sources and the core, and owns the core's `reset`, `in*`, `is_last` and `byte_num` pins.

---
 rtl/keccak_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/keccak_arbiter.sv
// keccak_arbiter: round-robin scheduler that lends a single keccak core to one
// of two requesters per message. It pulses the core reset before each message,
// forwards the owner's word stream with backpressure, and returns the digest
// to the owner with a one-cycle done pulse.
module keccak_arbiter (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   req,
    input  logic [63:0]  req_in,
    input  logic [1:0]   req_in_ready,
    input  logic [1:0]   req_is_last,
    input  logic [3:0]   req_byte_num,
    output logic [1:0]   grant,
    output logic [1:0]   req_buffer_full,
    output logic [1:0]   done,
    output logic [511:0] digest,
    output logic         core_reset,
    output logic [31:0]  core_in,
    output logic         core_in_ready,
    output logic         core_is_last,
    output logic [1:0]   core_byte_num,
    input  logic         core_buffer_full,
    input  logic [511:0] core_out,
    input  logic         core_out_ready
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CRST = 3'd1,
        S_FEED = 3'd2,
        S_WAIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     grant_q, grant_d;
    logic [1:0]     done_q, done_d;
    logic           last_grant_q, last_grant_d;
    logic [511:0]   digest_q, digest_d;

    // Owner index; grant is one-hot whenever it matters, so bit 1 selects.
    logic           owner;
    logic [31:0]    own_in;
    logic           own_ready;
    logic           own_last;
    logic [1:0]     own_bn;
    logic           word_accept;

    assign owner = grant_q[1];

    // Select the owner's word-stream signals; pure mux, no added latency.
    always_comb begin
        own_in    = owner ? req_in[63:32]      : req_in[31:0];
        own_ready = owner ? req_in_ready[1]    : req_in_ready[0];
        own_last  = owner ? req_is_last[1]     : req_is_last[0];
        own_bn    = owner ? req_byte_num[3:2]  : req_byte_num[1:0];
    end

    assign word_accept = (state_q == S_FEED) && own_ready && !core_buffer_full;

    // Next-state, grant arbitration, done pulse and digest capture.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        digest_d     = digest_q;
        done_d       = 2'b00;
        case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    // On a tie the requester that did not win last time goes.
                    if (req == 2'b11) begin
                        last_grant_d = ~last_grant_q;
                    end else begin
                        last_grant_d = req[1];
                    end
                    grant_d = last_grant_d ? 2'b10 : 2'b01;
                    state_d = S_CRST;
                end
            end
            S_CRST: begin
                state_d = S_FEED;
            end
            S_FEED: begin
                if (word_accept && own_last) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (core_out_ready) begin
                    digest_d = core_out;
                    done_d   = grant_q;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                grant_d = 2'b00;
                state_d = S_IDLE;
            end
            default: begin
                grant_d = 2'b00;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset discards any message in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            grant_q      <= 2'b00;
            last_grant_q <= 1'b1;
            done_q       <= 2'b00;
            digest_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            done_q       <= done_d;
            digest_q     <= digest_d;
        end
    end

    // Core pins and per-requester backpressure; only the owner in FEED sees the core.
    always_comb begin
        core_reset      = reset | (state_q == S_CRST);
        core_in         = 32'd0;
        core_in_ready   = 1'b0;
        core_is_last    = 1'b0;
        core_byte_num   = 2'd0;
        req_buffer_full = 2'b11;
        if (state_q == S_FEED) begin
            core_in       = own_in;
            core_in_ready = own_ready;
            core_is_last  = own_last;
            core_byte_num = own_bn;
            if (owner) begin
                req_buffer_full = {core_buffer_full, 1'b1};
            end else begin
                req_buffer_full = {1'b1, core_buffer_full};
            end
        end
    end

    assign grant  = grant_q;
    assign done   = done_q;
    assign digest = digest_q;

endmodule
